// File: rtl/pwm_output_guard_if.sv
// Channel bundle between the PWM generator, the frame/period strobes and the pin guard.
// With PWM_GUARD_FORCE_EN defined the bundle also carries force_en / force_val.
interface pwm_output_guard_if #(
    parameter int num_pwm = 12
);
    logic [num_pwm-1:0] pwm_in;
    logic               period_start;
    logic               frame_done;
    logic [num_pwm-1:0] pwm_out;
    logic               active;
    logic               timeout_flag;
`ifdef PWM_GUARD_FORCE_EN
    logic               force_en;
    logic [num_pwm-1:0] force_val;

    modport master (
        output pwm_in, period_start, frame_done, force_en, force_val,
        input  pwm_out, active, timeout_flag
    );
    modport slave (
        input  pwm_in, period_start, frame_done, force_en, force_val,
        output pwm_out, active, timeout_flag
    );
`else
    modport master (
        output pwm_in, period_start, frame_done,
        input  pwm_out, active, timeout_flag
    );
    modport slave (
        input  pwm_in, period_start, frame_done,
        output pwm_out, active, timeout_flag
    );
`endif
endinterface

// File: rtl/pwm_output_guard.sv
// Pin guard for PWM channels: idle until first frame, period-aligned on/off, frame watchdog.
// Optional raw output override enabled by defining PWM_GUARD_FORCE_EN.
module pwm_output_guard #(
    parameter int                 num_pwm         = 12,
    parameter int                 timeout_periods = 256,
    parameter logic [num_pwm-1:0] idle_level      = '0
) (
    input  logic              clk,
    input  logic              rst,
    pwm_output_guard_if.slave bus
);
    localparam int CW = $clog2(timeout_periods + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(timeout_periods - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(timeout_periods);

    typedef enum logic [1:0] {
        BLANK,
        ARMING,
        RUN,
        TIMEOUT
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic               timeout_q, timeout_nxt;
    logic               active_p1;
    logic [num_pwm-1:0] pwm_out_p1, pwm_out_nxt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CW'(1);
    endfunction

    function automatic logic [num_pwm-1:0] guard_level(input logic run,
                                                       input logic [num_pwm-1:0] raw);
        return run ? (raw ^ idle_level) : idle_level;
    endfunction

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        timeout_nxt = timeout_q;
        case (state)
            BLANK: begin
                if (bus.frame_done) begin
                    if (bus.period_start) begin
                        state_nxt = RUN;
                        count_nxt = '0;
                    end else begin
                        state_nxt = ARMING;
                    end
                end
            end
            ARMING: begin
                if (bus.period_start) begin
                    state_nxt = RUN;
                    count_nxt = '0;
                end
            end
            RUN: begin
                // A frame in the same cycle as a period boundary always wins.
                if (bus.frame_done) begin
                    count_nxt = '0;
                end else if (bus.period_start) begin
                    count_nxt = sat_inc(count);
                    if (count == CNT_LAST) begin
                        state_nxt   = TIMEOUT;
                        timeout_nxt = 1'b1;
                    end
                end
            end
            TIMEOUT: begin
                if (bus.frame_done) begin
                    timeout_nxt = 1'b0;
                    if (bus.period_start) begin
                        state_nxt = RUN;
                        count_nxt = '0;
                    end else begin
                        state_nxt = ARMING;
                    end
                end
            end
            default: state_nxt = BLANK;
        endcase

`ifdef PWM_GUARD_FORCE_EN
        if (bus.force_en) begin
            pwm_out_nxt = bus.force_val;
        end else begin
            pwm_out_nxt = guard_level(state_nxt == RUN, bus.pwm_in);
        end
`else
        pwm_out_nxt = guard_level(state_nxt == RUN, bus.pwm_in);
`endif
    end

    // Output stage: registered from the next state, so the sampling edge takes effect at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            count      <= '0;
            timeout_q  <= 1'b0;
            active_p1  <= 1'b0;
            pwm_out_p1 <= idle_level;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            timeout_q  <= timeout_nxt;
            active_p1  <= (state_nxt == RUN);
            pwm_out_p1 <= pwm_out_nxt;
        end
    end

    assign bus.pwm_out      = pwm_out_p1;
    assign bus.active       = active_p1;
    assign bus.timeout_flag = timeout_q;

endmodule
